// File: rtl/muldiv_unit_pkg.sv
// Shared pipeline definitions: ALU control codes, HI/LO unit op codes,
// multiply/divide FSM states and the iteration count.
package muldiv_unit_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_ITERS = 32;

    // ALU control codes used by the execute stage
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_ctrl_e;

    // HI/LO unit operations; codes 6 and 7 are undefined and ignored
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } muldiv_state_e;

    // Magnitude of a two's complement value when the op is signed, raw value otherwise
    function automatic logic [MD_WIDTH-1:0] md_mag(input logic [MD_WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[MD_WIDTH-1]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide on operand magnitudes, sign fix-up and HI/LO write-back in
// a final cycle, plus single-cycle MTHI/MTLO.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] LAST_ITER = 6'(MD_ITERS - 1);

    muldiv_state_e      state;
    logic [5:0]         cnt;
    logic [2*WIDTH-1:0] acc;      // shared shift register: {partial, multiplier} or {remainder, quotient}
    logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
    logic               is_div_q;
    logic               neg_q;    // negate product / quotient
    logic               rneg_q;   // negate remainder
    logic               dz_q;     // divide by zero

    logic               is_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // Operand magnitudes for the op presented at the start edge
    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        a_mag     = md_mag(a, is_signed);
        b_mag     = md_mag(b, is_signed);
    end

    // One multiply or divide iteration on the shared accumulator
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        // 34-bit trial so a zero divisor never looks like a borrow
        div_trial = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd};
        acc_next  = acc;
        if (is_div_q) begin
            if (!div_trial[WIDTH+1])
                acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
        end else if (acc[0]) begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

    // Sign fix-up and divide-by-zero result selection for the write-back
    always_comb begin
        prod   = neg_q ? (~acc + 64'd1) : acc;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div_q) begin
            res_hi = rneg_q ? (~acc[2*WIDTH-1:WIDTH] + 32'd1) : acc[2*WIDTH-1:WIDTH];
            if (dz_q)
                res_lo = '1;
            else
                res_lo = neg_q ? (~acc[WIDTH-1:0] + 32'd1) : acc[WIDTH-1:0];
        end
    end

    // Control FSM with registered busy and HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (start && !flush) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                acc      <= {{WIDTH{1'b0}}, b_mag};
                                opnd     <= a_mag;
                                is_div_q <= 1'b0;
                                neg_q    <= is_signed && (a[WIDTH-1] != b[WIDTH-1]);
                                rneg_q   <= 1'b0;
                                dz_q     <= 1'b0;
                                cnt      <= '0;
                                busy     <= 1'b1;
                                state    <= S_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                acc      <= {{WIDTH{1'b0}}, a_mag};
                                opnd     <= b_mag;
                                is_div_q <= 1'b1;
                                neg_q    <= is_signed && (a[WIDTH-1] != b[WIDTH-1]);
                                rneg_q   <= is_signed && a[WIDTH-1];
                                dz_q     <= (b == '0);
                                cnt      <= '0;
                                busy     <= 1'b1;
                                state    <= S_RUN;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + 6'd1;
                        if (cnt == LAST_ITER)
                            state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter: WIDTH, 32, operand/HI/LO width; only 32 SHALL be supported.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  request; sampled only in IDLE.
REQ-006 op  in  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 a  in  32  rs operand (dividend / multiplicand / MT source).
REQ-008 b  in  32  rt operand (divisor / multiplier).
REQ-009 flush  in  1  abort in-flight operation.
REQ-010 busy  out  1  unit occupied; pipeline stalls MFHI/MFLO/new muldiv while high.
REQ-011 hi  out  32  HI register.
REQ-012 lo  out  32  LO register.

Function
REQ-013 States SHALL be IDLE, RUN, FIX, with no others.
REQ-014 IDLE->RUN SHALL occur on start=1 with op in {MULT, MULTU, DIV, DIVU}; operands are latched at that edge.
REQ-015 RUN SHALL perform exactly 32 iterations, one per cycle: shift-add for multiply, restoring shift-subtract for divide, both on operand magnitudes (signed ops) or raw values (unsigned ops).
REQ-016 RUN->FIX SHALL occur after iteration 32; FIX->IDLE SHALL follow unconditionally after one cycle, writing HI/LO at that edge.
REQ-017 busy SHALL be a registered output, high in RUN and FIX: exactly 33 cycles after the start edge, then low in the same cycle that new HI/LO are visible.
REQ-018 Multiply SHALL set {hi,lo} = full 64-bit product; for MULT, the product is negated in FIX when sign(a) != sign(b).
REQ-019 Divide SHALL set lo=quotient and hi=remainder; for DIV, the quotient is negated when signs differ, and the remainder takes the sign of a.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0 (wrap, no trap).
REQ-021 Divide by zero (b=0, DIV or DIVU) SHALL still take 33 cycles and give lo=0xFFFFFFFF, hi=a.
REQ-022 MTHI/MTLO with start=1 in IDLE SHALL write a into hi/lo at that edge, leave the other register unchanged, and never assert busy.
REQ-023 start while busy=1 SHALL be ignored: no operand latch, no HI/LO change.
REQ-024 flush=1 in RUN or FIX SHALL return to IDLE next edge with busy=0 and HI/LO unchanged; flush has priority over the FIX write-back.
REQ-025 flush=1 and start=1 together in IDLE SHALL ignore start.
REQ-026 Undefined op codes with start=1 SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL force, asynchronously: state=IDLE, busy=0, hi=0, lo=0, iteration counter=0, internal accumulators=0.
REQ-028 Reset asserted mid-operation SHALL discard the operation, and the first start after release SHALL behave normally.

Structure
REQ-029 op encodings, state encodings and the iteration count (32) SHALL live in the shared pipeline defines/package alongside ALU control codes.
REQ-030 The design SHALL be one module with a single shared 64-bit shift register/accumulator and 6-bit counter, and no sub-module.

Verification
REQ-031 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
REQ-033 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100.
REQ-034 DIVU a=100, b=7 started; flush at cycle 10 -> busy=0 next cycle, hi/lo keep prior values; new start of 100/7 -> lo=14, hi=2.
REQ-035 MTLO a=0x1234 in IDLE -> lo=0x1234 next cycle, busy never high; MTHI issued while busy -> ignored.
REQ-036 rst_n pulsed low at cycle 20 of a MULT -> hi=lo=0 and busy=0 immediately; next MULTU 3*5 -> lo=15, hi=0.
